// File: rtl/svi_capture_bank_pkg.sv
// Shared types and defaults for the capture bank: capture modes, scan FSM states.
package svi_capture_bank_pkg;
  localparam int NCH_DEF = 8;
  localparam int W_DEF   = 4;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_CAPTURE = 2'd1,
    MODE_STICKY  = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;
endpackage

// File: rtl/svi_capture_bank_if.sv
// Per-channel bundle: x is the live input, y the captured value.
interface svi_capture_bank_if #(parameter int W = 4);
  logic [W-1:0] x;
  logic [W-1:0] y;
  modport chan (input x, output y);
endinterface

// File: rtl/svi_capture_chan.sv
// One channel: mode-driven update of y plus a sticky change flag cleared by scan.
module svi_capture_chan
  import svi_capture_bank_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  mode_e                   mode,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    ack,
  svi_capture_bank_if.chan        ch,
  output logic                    chg
);
  logic [W-1:0] y_nxt;

  always_comb begin
    y_nxt = ch.y;
    case (mode)
      MODE_PASS:    y_nxt = ch.x;
      MODE_CAPTURE: if (en) y_nxt = ch.x;
      MODE_STICKY:  if (en) y_nxt = ch.y | ch.x;
      default:      y_nxt = ch.y;
    endcase
  end

  // clear beats everything; a fresh change beats the scan acknowledge
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      ch.y <= '0;
      chg  <= 1'b0;
    end else if (clr) begin
      ch.y <= '0;
      chg  <= 1'b0;
    end else begin
      ch.y <= y_nxt;
      if (y_nxt != ch.y) chg <= 1'b1;
      else if (ack)      chg <= 1'b0;
    end
  end
endmodule

// File: rtl/svi_capture_bank.sv
// Bank of NCH capture channels with a ready/valid readout scan of captured values.
module svi_capture_bank
  import svi_capture_bank_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic [1:0]       i_mode,
  input  logic [NCH-1:0]   i_en,
  input  logic             i_clr,
  input  logic [NCH*W-1:0] i_d,
  output logic [NCH*W-1:0] o_q,
  output logic [NCH-1:0]   o_chg,
  input  logic             i_scan_start,
  input  logic             i_scan_ready,
  output logic             o_scan_valid,
  output logic [IW-1:0]    o_scan_idx,
  output logic [W-1:0]     o_scan_data,
  output logic             o_scan_done
);
  mode_e          mode;
  scan_state_e    state;
  logic [IW-1:0]  idx;
  logic [NCH-1:0] ack;

  assign mode = mode_e'(i_mode);

  svi_capture_bank_if #(.W(W)) chans [NCH] ();

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign chans[c].x      = i_d[c*W +: W];
    assign o_q[c*W +: W]   = chans[c].y;
    assign ack[c]          = o_scan_valid & i_scan_ready & (o_scan_idx == IW'(c));

    svi_capture_chan #(.W(W)) u_chan (
      .i_clk  (i_clk),
      .i_arst (i_arst),
      .mode   (mode),
      .en     (i_en[c]),
      .clr    (i_clr),
      .ack    (ack[c]),
      .ch     (chans[c]),
      .chg    (o_chg[c])
    );
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_scan_start) begin
          state <= ST_SCAN;
          idx   <= '0;
        end
        ST_SCAN: if (i_scan_ready) begin
          if (idx == IW'(NCH - 1)) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_scan_valid = (state == ST_SCAN);
  assign o_scan_done  = (state == ST_DONE);
  assign o_scan_idx   = o_scan_valid ? idx : '0;

  // data follows y live, so a capture into the presented channel shows immediately
  always_comb begin
    o_scan_data = '0;
    if (o_scan_valid)
      for (int c = 0; c < NCH; c++)
        if (idx == IW'(c)) o_scan_data = o_q[c*W +: W];
  end
endmodule

// File: doc/svi_capture_bank.md
SVI_CAPTURE_BANK -- requirements
Module: svi_capture_bank

Interface
REQ-001 Parameter NCH, default 8, number of channels (1..32).
REQ-002 Parameter W, default 4, data width per channel (1..16).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_arst  input  1  reset, asynchronous assert, active-low.
REQ-005 i_mode  input  2  global capture mode: 0 PASS, 1 CAPTURE, 2 STICKY, 3 HOLD.
REQ-006 i_en  input  NCH  per-channel capture enable.
REQ-007 i_clr  input  1  synchronous clear of all captured values and change flags.
REQ-008 i_d  input  NCH*W  per-channel input data, channel c at bits [c*W +: W].
REQ-009 o_q  output  NCH*W  per-channel captured data, same packing as i_d.
REQ-010 o_chg  output  NCH  per-channel sticky change flag.
REQ-011 i_scan_start  input  1  one-cycle request to start a readout scan.
REQ-012 i_scan_ready  input  1  consumer ready for the current scan beat.
REQ-013 o_scan_valid, o_scan_idx ($clog2(NCH) bits, min 1), o_scan_data (W bits), o_scan_done (1): scan output beat, channel index, channel data, and end-of-scan pulse.

Function
REQ-014 Each channel SHALL hold its input (x) and captured value (y) as members of one element of an array of NCH interface instances; o_q SHALL be driven from the y members.
REQ-015 PASS: y <= x every cycle, regardless of i_en.
REQ-016 CAPTURE: y <= x when i_en[c]=1; otherwise hold (registered equivalent of the enabled latch).
REQ-017 STICKY: y <= y | x when i_en[c]=1; otherwise hold.
REQ-018 HOLD: y holds; i_en ignored.
REQ-019 Capture latency SHALL be one cycle from i_d/i_en to o_q.
REQ-020 o_chg[c] SHALL set in any cycle where the next y differs from current y, and SHALL stay set until cleared.
REQ-021 o_chg[c] SHALL clear on an accepted scan beat for channel c (o_scan_valid & i_scan_ready & o_scan_idx==c); a set in the same cycle SHALL win.
REQ-022 i_clr SHALL force all y to 0 and all o_chg to 0 on the next edge, overriding mode, i_en and change-set. It SHALL NOT affect the scan FSM.
REQ-023 Scan FSM states: IDLE, SCAN, DONE.
REQ-024 IDLE -> SCAN on i_scan_start, with index 0. i_scan_start is ignored outside IDLE.
REQ-025 In SCAN: o_scan_valid=1, o_scan_data = current y[o_scan_idx] (combinational from registered state). The index advances only on i_scan_ready. Valid and data SHALL stay stable for the beat while ready=0, except that data reflects a y update to that channel.
REQ-026 SCAN -> DONE on the accepted beat with index NCH-1. DONE asserts o_scan_done for exactly one cycle, then -> IDLE.
REQ-027 In IDLE and DONE: o_scan_valid=0, o_scan_idx=0, o_scan_data=0.
REQ-028 NCH=1 SHALL work: SCAN lasts one accepted beat, then DONE.

Reset
REQ-029 On i_arst low, immediately and independent of i_clk: o_q=0, o_chg=0, FSM=IDLE, o_scan_valid=0, o_scan_idx=0, o_scan_done=0.
REQ-030 Reset asserted mid-scan SHALL abort the scan without o_scan_done.
REQ-031 On deassertion, the first active edge SHALL behave as a normal cycle.

Structure
REQ-032 A shared package SHALL hold the mode enum (PASS/CAPTURE/STICKY/HOLD), the scan state enum, and default NCH/W constants.
REQ-033 The channel interface SHALL be parameterised by W, with members x and y.
REQ-034 One sub-module, svi_capture_chan, SHALL implement the per-channel y/chg update; it SHALL be instantiated NCH times in a generate loop.
REQ-035 The scan FSM SHALL live in svi_capture_bank.

Verification
REQ-036 Reset, then i_mode=CAPTURE, i_en=8'h05, i_d all channels 4'hA -> next cycle o_q ch0 and ch2 = A, others 0; o_chg=8'h05.
REQ-037 STICKY with ch3 fed 4'h1, then 4'h4, i_en[3]=1 -> o_q ch3 goes 1, then 5; a repeated 4'h4 leaves o_chg[3] set with no new change.
REQ-038 Scan with i_scan_ready toggling 1,0,1,... -> idx 0..7 each presented until accepted; o_scan_done pulses once 1 cycle after the idx-7 accept; o_chg all 0 afterward if no changes occurred.
REQ-039 Change on ch2 in the same cycle its beat is accepted -> o_chg[2] remains 1.
REQ-040 i_clr during PASS with nonzero i_d -> o_q=0, o_chg=0 for that cycle; data reappears one cycle after i_clr drops.
REQ-041 i_arst pulsed low while idx=4 in SCAN -> o_scan_valid=0 immediately, no o_scan_done, FSM in IDLE.
